// File: rtl/seq_mul_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package seq_mul_pkg;

   localparam int unsigned DEFAULT_WIDTH = 16;
   localparam int unsigned CNT_W         = $clog2(DEFAULT_WIDTH);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/seq_mul_add_stage.sv
// Combinational WIDTH-bit ripple-carry adder, one full adder per bit.
module seq_mul_add_stage #(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH-1:0] input1,
   input  logic [WIDTH-1:0] input2,
   input  logic             inputc,
   output logic [WIDTH-1:0] sum,
   output logic             outc
);

   logic [WIDTH:0] carry;

   assign carry[0] = inputc;

   // Full-adder chain: carry ripples from bit 0 upward.
   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      assign sum[i]     = input1[i] ^ input2[i] ^ carry[i];
      assign carry[i+1] = (input1[i] & input2[i]) | (carry[i] & (input1[i] ^ input2[i]));
   end

   assign outc = carry[WIDTH];

endmodule

// File: rtl/seq_multiplier16.sv
// Multi-cycle unsigned shift-and-add multiplier: one adder reused over WIDTH iterations,
// registered product/ovf16 and a start/busy/done handshake.
module seq_multiplier16
   import seq_mul_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   input1,
   input  logic [WIDTH-1:0]   input2,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product,
   output logic               ovf16
);

   localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   state_e               state_q;
   logic [CntW-1:0]      cnt_q;
   logic [WIDTH-1:0]     mcand_q;
   logic [2*WIDTH-1:0]   acc_q;
   logic [2*WIDTH-1:0]   product_q;
   logic                 ovf16_q;
   logic                 busy_q;
   logic                 done_q;

   logic [WIDTH-1:0]     addend;
   logic [WIDTH-1:0]     hi_sum;
   logic                 hi_carry;
   logic [2*WIDTH-1:0]   acc_d;

   // Add the multiplicand into the upper half only when the current multiplier bit is set.
   always_comb begin
      addend = acc_q[0] ? mcand_q : '0;
   end

   seq_mul_add_stage #(
      .WIDTH (WIDTH)
   ) u_add_stage (
      .input1 (acc_q[2*WIDTH-1:WIDTH]),
      .input2 (addend),
      .inputc (1'b0),
      .sum    (hi_sum),
      .outc   (hi_carry)
   );

   // Logical right shift that pulls the adder carry into the top bit, so nothing is truncated.
   always_comb begin
      acc_d = {hi_carry, hi_sum, acc_q[WIDTH-1:1]};
   end

   // FSM, iteration counter, shift register and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         mcand_q   <= '0;
         acc_q     <= '0;
         product_q <= '0;
         ovf16_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  mcand_q <= input1;
                  acc_q   <= {{WIDTH{1'b0}}, input2};
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= StRun;
               end
            end
            StRun: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + CntW'(1);
               if (cnt_q == LastCnt) begin
                  product_q <= acc_d;
                  ovf16_q   <= |acc_d[2*WIDTH-1:WIDTH];
                  done_q    <= 1'b1;
                  state_q   <= StDone;
               end
            end
            StDone: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;
   assign ovf16   = ovf16_q;

endmodule

// File: tb/tb_seq_multiplier16.sv
// Directed self-checking bench for seq_multiplier16.
module tb_seq_multiplier16;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] input1;
   logic [15:0] input2;
   logic        busy;
   logic        done;
   logic [31:0] product;
   logic        ovf16;

   int          total;
   int          bad;
   logic [31:0] last_prod;
   logic        last_ovf;

   seq_multiplier16 #(
      .WIDTH (16)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .input1  (input1),
      .input2  (input2),
      .busy    (busy),
      .done    (done),
      .product (product),
      .ovf16   (ovf16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Called at a negedge with the DUT idle. Optionally pulses a second start at cycle inj_cyc.
   task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input int inj_cyc, input logic [15:0] ia, input logic [15:0] ib,
                        input logic [31:0] exp_p, input logic exp_o);
      int   cyc;
      logic seen;
      input1 = a;
      input2 = b;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      input1 = 16'($urandom);
      input2 = 16'($urandom);
      cyc    = 0;
      seen   = 1'b0;
      while (!seen && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (inj_cyc != 0 && cyc == inj_cyc) begin
            start  = 1'b1;
            input1 = ia;
            input2 = ib;
         end else if (inj_cyc != 0 && cyc == inj_cyc + 1) begin
            start  = 1'b0;
         end
         seen = done;
         check({tag, ":busy"}, 64'(busy), 64'd1);
         if (!seen) begin
            check({tag, ":held_prod"}, 64'(product), 64'(last_prod));
            check({tag, ":held_ovf"}, 64'(ovf16), 64'(last_ovf));
         end
      end
      check({tag, ":latency"}, 64'(cyc), 64'd17);
      check({tag, ":product"}, 64'(product), 64'(exp_p));
      check({tag, ":ovf16"}, 64'(ovf16), 64'(exp_o));
      last_prod = exp_p;
      last_ovf  = exp_o;
      @(negedge clk);
      check({tag, ":done_drop"}, 64'(done), 64'd0);
      check({tag, ":busy_drop"}, 64'(busy), 64'd0);
      check({tag, ":idle_prod"}, 64'(product), 64'(exp_p));
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      last_prod = '0;
      last_ovf  = 1'b0;
      rst_n     = 1'b0;
      start     = 1'b0;
      input1    = '0;
      input2    = '0;

      // Reset then idle
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("rst_idle:product", 64'(product), 64'd0);
         check("rst_idle:busy", 64'(busy), 64'd0);
         check("rst_idle:done", 64'(done), 64'd0);
         check("rst_idle:ovf16", 64'(ovf16), 64'd0);
         @(negedge clk);
      end

      do_op("basic", 16'd24, 16'd32, 0, 16'd0, 16'd0, 32'd768, 1'b0);
      do_op("wide", 16'd3105, 16'd11275, 0, 16'd0, 16'd0, 32'd35008875, 1'b1);
      do_op("max", 16'd65535, 16'd65535, 0, 16'd0, 16'd0, 32'd4294836225, 1'b1);
      do_op("zero", 16'd0, 16'd52, 0, 16'd0, 16'd0, 32'd0, 1'b0);
      do_op("ident", 16'd1, 16'd65535, 0, 16'd0, 16'd0, 32'd65535, 1'b0);
      do_op("busy_ign", 16'd44, 16'd9, 5, 16'd202, 16'd97, 32'd396, 1'b0);
      do_op("after_ign", 16'd202, 16'd97, 0, 16'd0, 16'd0, 32'd19594, 1'b0);

      // Reset mid-operation: no done pulse, product and flags cleared
      input1 = 16'd644;
      input2 = 16'd255;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int i = 1; i < 8; i++) @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("midrst:product", 64'(product), 64'd0);
      check("midrst:busy", 64'(busy), 64'd0);
      check("midrst:done", 64'(done), 64'd0);
      check("midrst:ovf16", 64'(ovf16), 64'd0);
      last_prod = '0;
      last_ovf  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("midrst:no_done", 64'(done), 64'd0);
         check("midrst:no_busy", 64'(busy), 64'd0);
      end

      do_op("post_rst", 16'd86, 16'd572, 0, 16'd0, 16'd0, 32'd49192, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_multiplier16.md
Name: seq_multiplier16

Overview:
- Multi-cycle unsigned shift-and-add multiplier built on the team's ripple-carry adder datapath.
- Sits downstream of the operand registers, alongside the 16-bit adder/subtractor, in the arithmetic unit.
- Reuses one WIDTH-bit adder across WIDTH iterations instead of building a combinational array multiplier.
- Produces a 2*WIDTH-bit product, an overflow-of-narrow-result flag and a start/busy/done handshake.

Parameters:
WIDTH, 16, operand width in bits; product is 2*WIDTH bits; iteration count equals WIDTH.

Ports:
clk  input  1  single system clock; all state updates on the rising edge.
rst_n  input  1  reset, synchronous and active-low.
start  input  1  request pulse; sampled only in IDLE.
input1  input  WIDTH  multiplicand, unsigned; sampled with start.
input2  input  WIDTH  multiplier, unsigned; sampled with start.
busy  output  1  high in RUN and DONE.
done  output  1  one-cycle pulse; product valid.
product  output  2*WIDTH  unsigned result; held until the next accepted start or reset.
ovf16  output  1  product[2*WIDTH-1:WIDTH] != 0; valid whenever done is high, and held with product.

Behaviour:
- Reset, sampled on a clk edge with rst_n=0:
  - state=IDLE, iteration counter=0.
  - product=0, busy=0, done=0, ovf16=0.
  - Internal operand and accumulator registers are cleared.
  - Reset overrides everything, including a simultaneous start and an operation already in RUN.
  - An aborted operation produces no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at edge E: latch mcand=input1 and acc={WIDTH'0, input2}, clear the counter, go to RUN.
  - busy rises after edge E.
  - If start=0: stay in IDLE; product and ovf16 keep their previous values.
- RUN, one iteration per edge:
  - {c, hi} = acc[2W-1:W] + (acc[0] ? mcand : 0), WIDTH+1 bits with carry.
  - acc <= {c, hi, acc[W-1:1]}, i.e. a logical right shift that brings the carry in.
  - Counter increments.
  - On the edge that completes iteration WIDTH-1, go to DONE and load product<=final acc and ovf16.
  - For WIDTH=16, with start at edge E, iterations run on edges E+1..E+16.
- DONE:
  - done=1 for exactly one cycle, the cycle after edge E+16; busy=1.
  - Next edge returns to IDLE; done=0, busy=0.
  - Total latency from start sample to done high is WIDTH+1 cycles.
  - Throughput is one operation per WIDTH+2 cycles: a new start is accepted in the first IDLE cycle after DONE.
- start while busy=1 is ignored: no latch, no queue, no error.
- input1/input2 may change freely after the start edge; the result depends only on the values sampled with start.
- product stays at 0 until the first completion; it is never updated mid-RUN.
- Arithmetic and widths:
  - The carry out of the adder is always captured; no intermediate result may be truncated.
  - WIDTH=16 maximum: 65535*65535 = 4294836225 must be exact.
- Zero operands are not short-circuited: a run still takes the full WIDTH iterations.

Decomposition:
- Package seq_mul_pkg holds:
  - state enum {IDLE, RUN, DONE} with 2-bit encoding.
  - Counter width localparam $clog2(WIDTH).
  - DEFAULT_WIDTH=16.
- One sub-module, seq_mul_add_stage: combinational WIDTH-bit adder.
  - Ports input1, input2, inputc, sum, outc.
  - Ripple-carry full-adder chain, matching the existing adder datapath.
  - Instantiated once, with inputc tied to 0.
- FSM, counter and shift register stay in the top level.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles, release, keep start=0 for 5 cycles -> product=0, busy=0, done=0, ovf16=0 throughout.
- Basic multiply: input1=24, input2=32, pulse start -> done high exactly 17 cycles after the start edge, product=768, ovf16=0; busy high for those 17 cycles.
- Wide result: input1=3105, input2=11275 -> product=35008875, ovf16=1; input1=65535, input2=65535 -> product=4294836225, ovf16=1.
- Zero and identity: 0*52 -> product=0; 1*65535 -> product=65535, ovf16=0; both take the full 17-cycle latency.
- Start while busy: start 44*9, pulse start with 202*97 at cycle 5 -> ignored; done at 17 with product=396; a fresh start issued immediately after returning to IDLE gives 19594.
- Reset mid-operation: start 644*255, assert rst_n=0 at cycle 8 for one edge -> product=0, busy=0, no done pulse; a subsequent 86*572 gives 49192.
